// File: rtl/fnd_scan_ctrl_if.sv
// Control/data bundle between the BCD formatter, the scan controller and the segment decoder.
interface fnd_scan_if #(
  parameter int DIGITS = 4
);
  localparam int IDX_W = $clog2(DIGITS);

  logic                  en;
  logic                  dir;
  logic [DIGITS-1:0]     digit_en;
  logic [4*DIGITS-1:0]   data;
  logic [IDX_W-1:0]      digit_idx;
  logic [DIGITS-1:0]     com;
  logic [3:0]            bcd;
  logic                  tick;
  logic                  frame;

  modport master (
    output en, dir, digit_en, data,
    input  digit_idx, com, bcd, tick, frame
  );

  modport slave (
    input  en, dir, digit_en, data,
    output digit_idx, com, bcd, tick, frame
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment digit scanner: prescaled step tick, masked circular
// digit search in either direction, active-low common select plus BCD nibble.
module fnd_scan_ctrl #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 100000
) (
  input  logic      i_clk,
  input  logic      i_reset_n,
  fnd_scan_if.slave bus
);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0]     presc;
  logic [IDX_W-1:0]  idx, idx_hit, idx_next;
  logic              hit, step, wrap;
  logic [DIGITS-1:0] com_q, com_next;
  logic [3:0]        bcd_q, bcd_next;
  logic              tick_q, frame_q;

  assign step = bus.en && (presc == PRESC_MAX);

  // Walk outward from idx; the nearest enabled digit wins because it is written last.
  // Distance DIGITS lands back on idx itself, covering the single-digit mask.
  always_comb begin
    int c;
    c       = 0;
    hit     = 1'b0;
    idx_hit = idx;
    for (int k = DIGITS; k >= 1; k--) begin
      if (bus.dir) begin
        c = int'(idx) - k;
        if (c < 0) c = c + DIGITS;
      end else begin
        c = int'(idx) + k;
        if (c >= DIGITS) c = c - DIGITS;
      end
      if (bus.digit_en[IDX_W'(c)]) begin
        hit     = 1'b1;
        idx_hit = IDX_W'(c);
      end
    end
  end

  assign wrap     = hit && (bus.dir ? (idx_hit >= idx) : (idx_hit <= idx));
  assign idx_next = (step && hit) ? idx_hit : idx;

  always_comb begin
    com_next = '1;
    bcd_next = '0;
    for (int k = 0; k < DIGITS; k++) begin
      com_next[k] = !((idx_next == IDX_W'(k)) && bus.digit_en[k]);
      if (idx_next == IDX_W'(k)) bcd_next = bus.data[4*k +: 4];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc   <= '0;
      idx     <= '0;
      com_q   <= '1;
      bcd_q   <= '0;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else if (!bus.en) begin
      // Disabled: blank and restart the prescaler, keep the position and nibble.
      presc   <= '0;
      com_q   <= '1;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      presc   <= step ? '0 : presc + 1'b1;
      idx     <= idx_next;
      com_q   <= com_next;
      bcd_q   <= bcd_next;
      tick_q  <= step;
      frame_q <= step && wrap;
    end
  end

  assign bus.digit_idx = idx;
  assign bus.com       = com_q;
  assign bus.bcd       = bcd_q;
  assign bus.tick      = tick_q;
  assign bus.frame     = frame_q;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed scan sequences for a 4-digit, divide-by-3 controller; expected steps queued then matched per tick.
module tb_fnd_scan_ctrl;
  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fnd_scan_if #(.DIGITS(DIGITS)) bus ();

  fnd_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         gap;
    logic [1:0] idx;
    logic [3:0] com;
    logic [3:0] bcd;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int gap, input logic [1:0] idx, input logic [3:0] com,
                      input logic [3:0] bcd, input logic frame);
    exp_t e;
    e.gap = gap; e.idx = idx; e.com = com; e.bcd = bcd; e.frame = frame;
    q.push_back(e);
  endtask

  // Wait (bounded) for each tick and compare it against the next queued step.
  task automatic drain(input string tag);
    exp_t e;
    int   n;
    while (q.size() > 0) begin
      e = q.pop_front();
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.tick && n < 20);
      chk({tag, "_gap"},   n,         e.gap);
      chk({tag, "_idx"},   bus.digit_idx, e.idx);
      chk({tag, "_com"},   bus.com,   e.com);
      chk({tag, "_bcd"},   bus.bcd,   e.bcd);
      chk({tag, "_frame"}, bus.frame, e.frame);
    end
  endtask

  initial begin
    bus.en       = 1'b0;
    bus.dir      = 1'b0;
    bus.digit_en = 4'hF;
    bus.data     = 16'h4321;
    repeat (2) @(negedge clk);
    chk("rst_idx",   bus.digit_idx, 0);
    chk("rst_com",   bus.com,   4'hF);
    chk("rst_bcd",   bus.bcd,   0);
    chk("rst_tick",  bus.tick,  0);
    chk("rst_frame", bus.frame, 0);

    // Upward scan over all digits
    rst_n  = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);
    chk("t1_pre_com",  bus.com,  4'b1110);
    chk("t1_pre_bcd",  bus.bcd,  1);
    chk("t1_pre_tick", bus.tick, 0);
    push(2, 1, 4'b1101, 2, 0);
    push(3, 2, 4'b1011, 3, 0);
    push(3, 3, 4'b0111, 4, 0);
    push(3, 0, 4'b1110, 1, 1);
    drain("t1");

    // Data change shows up one edge later without a step
    push(3, 1, 4'b1101, 2, 0);
    drain("t4a");
    bus.data = 16'h4391;
    @(negedge clk);
    chk("t4_bcd9", bus.bcd, 9);
    chk("t4_idx",  bus.digit_idx, 1);

    // Sparse mask 1010 upward
    bus.digit_en = 4'b1010;
    push(2, 3, 4'b0111, 4, 0);
    push(3, 1, 4'b1101, 9, 1);
    push(3, 3, 4'b0111, 4, 0);
    drain("t2");

    // Downward scan
    bus.dir      = 1'b1;
    bus.digit_en = 4'hF;
    bus.data     = 16'h4321;
    push(3, 2, 4'b1011, 3, 0);
    push(3, 1, 4'b1101, 2, 0);
    push(3, 0, 4'b1110, 1, 0);
    push(3, 3, 4'b0111, 4, 1);
    push(3, 2, 4'b1011, 3, 0);
    push(3, 1, 4'b1101, 2, 0);
    push(3, 0, 4'b1110, 1, 0);
    drain("t3");

    // Empty mask, then a single enabled digit
    bus.digit_en = 4'b0000;
    push(3, 0, 4'b1111, 1, 0);
    push(3, 0, 4'b1111, 1, 0);
    drain("t5z");
    bus.digit_en = 4'b0100;
    push(3, 2, 4'b1011, 3, 1);
    push(3, 2, 4'b1011, 3, 1);
    push(3, 2, 4'b1011, 3, 1);
    drain("t5s");

    // Enable drop mid-count
    @(negedge clk);
    bus.en       = 1'b0;
    bus.dir      = 1'b0;
    bus.digit_en = 4'hF;
    repeat (5) begin
      @(negedge clk);
      chk("t6_off_com",  bus.com,  4'hF);
      chk("t6_off_idx",  bus.digit_idx, 2);
      chk("t6_off_tick", bus.tick, 0);
    end
    bus.en = 1'b1;
    push(3, 3, 4'b0111, 4, 0);
    drain("t6en");

    // Reset asserted with the prescaler one edge short of a step
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_idx",   bus.digit_idx, 0);
    chk("t6_rst_com",   bus.com,   4'hF);
    chk("t6_rst_bcd",   bus.bcd,   0);
    chk("t6_rst_tick",  bus.tick,  0);
    chk("t6_rst_frame", bus.frame, 0);
    @(negedge clk);
    chk("t6_rst_hold_tick", bus.tick, 0);
    chk("t6_rst_hold_idx",  bus.digit_idx, 0);
    rst_n = 1'b1;
    push(3, 1, 4'b1101, 2, 0);
    drain("t6rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
